lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum ACCESS cycles to wait for MemReady before aborting.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  1  pipeline requests a memory operation.
REQ-005 req_write  input  1  1=store, 0=load.
REQ-006 req_funct3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-justified.
REQ-009 req_ready  output  1  high only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-010 resp_valid  output  1  one-cycle pulse per accepted request.
REQ-011 resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-012 resp_err  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid with resp_valid.
REQ-013 stall  output  1  high whenever state != IDLE.
REQ-014 MemRead, MemWrite  output  1 each  memory strobes.
REQ-015 DMType  output  3  registered req_funct3.
REQ-016 Address, Write_data  output  32 each  registered req_addr and req_wdata.
REQ-017 Read_data  input  32  memory read data; registered in the memory, already sign- or zero-extended.
REQ-018 MemReady  input  1  memory has completed the current strobe.

Function
REQ-019 FSM states: IDLE, ACCESS, CAPTURE, RESP.
REQ-020 On acceptance, the LSU registers funct3, addr, wdata and write into the request registers.
REQ-021 Illegal funct3: 011 or 11x, or a store with funct3[2]=1 -> next state RESP, err 11, no strobe.
REQ-022 Misaligned: h/hu with addr[0]=1, or w with addr[1:0]!=00 -> next state RESP, err 01, no strobe; the illegal check takes priority.
REQ-023 Any other accepted request -> next state ACCESS.
REQ-024 ACCESS: MemWrite=req_write and MemRead=!req_write; the strobe is held until MemReady is sampled high.
REQ-025 ACCESS with MemReady: a store goes to RESP; a load goes to CAPTURE.
REQ-026 CAPTURE: strobes are low; Read_data is latched into resp_rdata at the end of the cycle; next state RESP.
REQ-027 RESP: resp_valid=1 for exactly one cycle, then IDLE.
REQ-028 Latency with a single-cycle memory: request accepted at cycle N gives store resp_valid at N+2, load at N+3, error at N+1.
REQ-029 Timeout counter: cleared on entering ACCESS; increments each ACCESS cycle without MemReady.
REQ-030 When the timeout count reaches TIMEOUT-1 without MemReady, strobes drop, next state RESP, err 10, rdata 0.
REQ-031 MemReady sampled outside ACCESS is ignored.
REQ-032 req_valid while not in IDLE is ignored; no queueing; the requester holds its request.
REQ-033 Back-to-back: a request may be accepted in the IDLE cycle directly following RESP.
REQ-034 Address, Write_data and DMType stay stable from ACCESS entry until return to IDLE.

Reset
REQ-035 rstn low forces IDLE asynchronously and zeroes the request registers and the timeout counter.
REQ-036 Output reset values: req_ready=1; stall=0; resp_valid=0; resp_rdata=0; resp_err=00; MemRead=0; MemWrite=0; DMType=000; Address=0; Write_data=0.
REQ-037 A reset mid-transaction abandons the operation; no resp_valid is produced for it.

Structure
REQ-038 Shared package lsu_pkg holds the state encoding, the funct3 constants (LB, LH, LW, LBU, LHU) and the resp_err codes.
REQ-039 One combinational sub-module, lsu_chk, performs the illegal and misaligned classification; everything else stays in lsu.

Verification
REQ-040 Store: write=1, funct3=010, addr=0x10, wdata=0xDEADBEEF -> MemWrite high for 1 cycle; resp_valid at N+2, err 00; a subsequent LW to 0x10 returns 0xDEADBEEF at N+3.
REQ-041 Load byte: memory word 0x000000F0, LB then LBU at 0x20 -> rdata 0xFFFFFFF0 then 0x000000F0.
REQ-042 Misaligned: LW at 0x22 and LH at 0x21 -> resp_valid at N+1, err 01, MemRead never high.
REQ-043 Illegal funct3: store with funct3=100 -> err 11 at N+1; no strobe.
REQ-044 Timeout: MemReady forced 0, TIMEOUT=16 -> MemRead high 16 cycles, then resp err 10; stall high throughout.
REQ-045 Reset: rstn pulsed low during CAPTURE -> outputs reach reset values immediately, no resp_valid, next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, RISC-V funct3
// access types, response error codes and the captured request record.
package lsu_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_chk.sv
// Combinational request classifier: flags illegal access types and
// misaligned addresses and produces the matching response error code.
module lsu_chk
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  logic       write,
  output logic       reject,
  output logic [1:0] err
);

  logic illegal;
  logic misaligned;

  always_comb begin
    // Stores have no signed/unsigned variants, so funct3[2] is illegal there.
    illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (write && funct3[2]);
    misaligned = 1'b0;
    if (!illegal) begin
      case (funct3)
        LH, LHU: misaligned = addr_lo[0];
        LW:      misaligned = (addr_lo != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
    reject = illegal || misaligned;
    if (illegal)         err = ERR_ILLEGAL;
    else if (misaligned) err = ERR_MISALIGN;
    else                 err = ERR_OK;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, drives the memory strobes
// until MemReady or timeout, and returns a single-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        stall,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  DMType,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data,
  input  logic        MemReady
);

  localparam int              CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  lsu_req_t         req_q;
  logic [CNT_W-1:0] tcnt;
  logic [31:0]      rdata_q;
  logic [1:0]       err_q;

  logic             accept;
  logic             in_access;
  logic             mem_done;
  logic             timed_out;
  logic             chk_reject;
  logic [1:0]       chk_err;

  lsu_chk u_chk (
    .funct3  (req_funct3),
    .addr_lo (req_addr[1:0]),
    .write   (req_write),
    .reject  (chk_reject),
    .err     (chk_err)
  );

  assign accept    = req_valid && (state == ST_IDLE);
  assign in_access = (state == ST_ACCESS);
  assign mem_done  = in_access && MemReady;
  // MemReady wins over the timeout in the last permitted ACCESS cycle.
  assign timed_out = in_access && !MemReady && (tcnt == TCNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = chk_reject ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem_done)       state_nxt = req_q.write ? ST_RESP : ST_CAPTURE;
        else if (timed_out) state_nxt = ST_RESP;
      end
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Request registers: loaded only on acceptance, so they stay stable
  // for the whole transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.write  <= req_write;
      req_q.funct3 <= req_funct3;
      req_q.addr   <= req_addr;
      req_q.wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt <= '0;
    end else if (accept) begin
      tcnt <= '0;
    end else if (in_access && !MemReady && !timed_out) begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

  // Response payload: cleared on acceptance so stores and errors return 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else if (accept) begin
      rdata_q <= '0;
      err_q   <= chk_err;
    end else if (timed_out) begin
      err_q   <= ERR_TIMEOUT;
    end else if (state == ST_CAPTURE) begin
      rdata_q <= Read_data;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign stall      = (state != ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign MemRead    = in_access && !req_q.write;
  assign MemWrite   = in_access && req_q.write;
  assign DMType     = req_q.funct3;
  assign Address    = req_q.addr;
  assign Write_data = req_q.wdata;

endmodule
